// File: rtl/gate_bist_ctrl_if.sv
// Host-facing and gate-model-facing signals of the BIST sequencer.
// Handshake: the host holds start high for at least one cycle while the sequencer is
// idle (busy=0, done=0). The run begins on the next rising edge. completion is a single-cycle
// done pulse, with pass valid from that pulse until the next accepted start.
interface gate_bist_ctrl_if;
  logic        start;
  logic        abort;
  logic        mode;
  logic [12:0] num_vectors;
  logic [15:0] golden;
  logic [11:0] dut_in;
  logic [9:0]  dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  modport master (
    output start, abort, mode, num_vectors, golden, dut_out,
    input  dut_in, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, mode, num_vectors, golden, dut_out,
    output dut_in, busy, done, pass, signature
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: applies counter or LFSR vectors to a 12-in/10-out gate model,
// compacts its outputs in a 16-bit MISR and compares against a golden signature.
module gate_bist_ctrl #(
  parameter int          SETTLE    = 2,
  parameter logic [11:0] LFSR_SEED = 12'h001
) (
  input  logic              clk,
  input  logic              rst,
  gate_bist_ctrl_if.slave   bus,
  output logic [1:0]        o_dbg_state
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_mode;
  logic [12:0] r_remaining;
  logic [3:0]  r_cnt;
  logic [11:0] r_dut_in;
  logic [15:0] r_sig;
  logic        r_pass;

  logic        w_sample;
  logic        w_last;
  logic        w_match;
  logic [11:0] w_lfsr_next;
  logic [11:0] w_vec_next;
  logic [15:0] w_misr_next;

  assign w_sample    = (r_state == S_RUN) && (r_cnt == SETTLE_C);
  assign w_last      = w_sample && (r_remaining == 13'd1);
  assign w_match     = (r_sig == bus.golden);
  assign w_lfsr_next = {r_dut_in[10:0], r_dut_in[11] ^ r_dut_in[5] ^ r_dut_in[3] ^ r_dut_in[0]};
  assign w_vec_next  = r_mode ? w_lfsr_next : (r_dut_in + 12'd1);
  assign w_misr_next = {r_sig[14:0], r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10]}
                       ^ {6'b0, bus.dut_out};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = (bus.num_vectors == 13'd0) ? S_DONE : S_RUN;
      S_RUN: begin
        // abort takes priority over a coincident final sample
        if (bus.abort)   w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_remaining <= 13'd0;
      r_cnt       <= 4'd0;
      r_dut_in    <= 12'd0;
      r_sig       <= 16'd0;
      r_pass      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode      <= bus.mode;
            r_remaining <= bus.num_vectors;
            r_cnt       <= 4'd0;
            r_sig       <= 16'd0;
            r_pass      <= 1'b0;
            if (bus.num_vectors != 13'd0)
              r_dut_in <= bus.mode ? LFSR_SEED : 12'h000;
          end
        end
        S_RUN: begin
          if (!bus.abort) begin
            if (w_sample) begin
              r_sig       <= w_misr_next;
              r_cnt       <= 4'd0;
              r_remaining <= r_remaining - 13'd1;
              if (!w_last) r_dut_in <= w_vec_next;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_DONE:  r_pass <= w_match;
        default: ;
      endcase
    end
  end

  assign bus.dut_in    = r_dut_in;
  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.pass      = (r_state == S_DONE) ? w_match : r_pass;
  assign bus.signature = r_sig;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test sequencer for the 12-input / 10-output combinational gate models in the gate library. It drives the model's inputs with either an exhaustive count or a 12-bit LFSR sequence, and waits a programmable settle time per vector. It compacts the model's outputs into a 16-bit MISR signature and compares the result with a golden value. It sits between the simulator's test host (start/done handshake) and one gate-model instance.

## Interface
- SETTLE, 2: extra hold cycles per vector before sampling (0..15); each vector occupies SETTLE+1 cycles
- LFSR_SEED, 12'h001: LFSR start value; must be nonzero
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a test run; sampled only in IDLE
- abort  in  1  cancel a running test; returns to IDLE without done
- mode  in  1  0 = exhaustive counter, 1 = LFSR; latched at start
- num_vectors  in  13  number of vectors to apply (0..8191); latched at start
- golden  in  16  expected signature; compared at end of run
- dut_in  out  12  registered stimulus to gate-model inputs N1..N12 (bit 0 = N1)
- dut_out  in  10  gate-model outputs, in fixed wiring order, bit 0 first
- busy  out  1  high while vectors are being applied
- done  out  1  one-cycle pulse at end of a completed run
- pass  out  1  signature == golden; valid from done until the next start
- signature  out  16  current MISR contents

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch mode and num_vectors; clear the MISR to 0.
  - load dut_in with the first vector: 12'h000 in exhaustive mode, LFSR_SEED in LFSR mode.
  - reset the settle counter and the remaining-vector counter, clear pass, go to RUN.
  - if num_vectors=0, go directly to DONE instead; dut_in is not changed.
- RUN:
  - the settle counter counts 0..SETTLE.
  - on the edge where the counter equals SETTLE: MISR samples dut_out, dut_in advances to the next vector, the counter clears, and remaining decrements.
  - on the sample of the last vector, go to DONE; dut_in is not advanced further.
- DONE: lasts one cycle with done=1 and pass=(signature==golden), then returns to IDLE.
- Exhaustive advance: dut_in+1 mod 4096; it wraps from 12'hFFF to 12'h000 when num_vectors>4096.
- LFSR advance:
  - fb = q[11]^q[5]^q[3]^q[0]
  - q_next = {q[10:0], fb}
- MISR update:
  - fb = s[15]^s[13]^s[12]^s[10]
  - s_next = {s[14:0], fb} ^ {6'b0, dut_out}
- start while in RUN or DONE is ignored.
- abort in RUN: go to IDLE next edge with busy=0 and done=0; signature and dut_in hold their last values, and pass stays 0. abort outside RUN is ignored.
- abort and a last-vector sample on the same edge: abort wins, no done.
- Changing golden during RUN is allowed; it is evaluated only in DONE. pass holds until the next start.

## Timing
- Reset values: dut_in=0, busy=0, done=0, pass=0, signature=0, state IDLE.
- Let k be the start edge (taken in IDLE):
  - busy=1 and dut_in is the first vector from edge k.
  - vector i is sampled at edge k+(i+1)(SETTLE+1).
  - done=1 and busy=0 in the cycle after edge k+N(SETTLE+1), where N=num_vectors.
  - the next start is accepted one cycle after done.
- num_vectors=0: done is high in the cycle after edge k; signature=0.
- dut_out is assumed combinationally stable within SETTLE+1 cycles of a dut_in change; there is no input register on dut_out.
- rst mid-run: all outputs return to reset values on that edge; no done pulse.

## Test plan
- Reset during RUN (mid-vector 2) -> next cycle: busy=0, done=0, dut_in=0, signature=0; a new start behaves normally.
- Exhaustive, SETTLE=2, num_vectors=4, dut_out=dut_in[9:0], golden=16'h0003:
  - dut_in = 0,1,2,3, each held 3 cycles.
  - signature after each sample = 0000, 0001, 0000, 0003.
  - done 12 cycles after start with pass=1.
- LFSR, LFSR_SEED=12'h001, num_vectors=5 -> dut_in = 001, 003, 007, 00F, 01E; no sixth advance.
- num_vectors=0, golden=0 -> done in the cycle after the start edge, pass=1, busy never high; golden=16'h0001 gives pass=0.
- Abort at the third vector, with start asserted continuously -> returns to IDLE with no done pulse and signature holding its value. The held start then restarts a run from vector 0 with the MISR cleared.
- Exhaustive, num_vectors=4097, SETTLE=0 -> dut_in wraps FFF->000 on the last vector; done 4097 cycles after start.
